// File: rtl/scale_coord_gen.sv
// scale_coord_gen: raster-order destination walker for the scale pixel stage.
// For every destination pixel it computes the fixed-point source position
// (integer sx/sy plus fractional fx/fy) and hands it to the pixel stage over a
// start/ready handshake, then pulses done once the last pixel is accepted.
// Optional build macro SCALE_CLAMP_EN: edge replication so that sx+1 / sy+1
// never leave the source image.
module scale_coord_gen #(
   parameter int DIM_W = 12,
   parameter int FRAC  = 18,
   parameter int FIX_W = 36
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             cfg_start,
   input  logic [DIM_W-1:0] cfg_dst_w,
   input  logic [DIM_W-1:0] cfg_dst_h,
   input  logic [FIX_W-1:0] cfg_step_x,
   input  logic [FIX_W-1:0] cfg_step_y,
   input  logic [DIM_W-1:0] cfg_src_w,
   input  logic [DIM_W-1:0] cfg_src_h,
   output logic             busy,
   output logic             done,
   input  logic             spg_ready,
   output logic             spg_start,
   output logic [DIM_W-1:0] spg_sx,
   output logic [DIM_W-1:0] spg_sy,
   output logic [FIX_W-1:0] spg_fx,
   output logic [FIX_W-1:0] spg_fy,
   output logic [FRAC-1:0]  spg_dx,
   output logic [FRAC-1:0]  spg_dy
);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t           state, state_nxt;
   logic [DIM_W-1:0] dst_w_q, dst_h_q, dst_w_nxt, dst_h_nxt;
   logic [DIM_W-1:0] src_w_q, src_h_q, src_w_nxt, src_h_nxt;
   logic [FIX_W-1:0] step_x_q, step_y_q, step_x_nxt, step_y_nxt;
   logic [FIX_W-1:0] acc_x_q, acc_y_q, acc_x_nxt, acc_y_nxt;
   logic [DIM_W-1:0] dx_q, dy_q, dx_nxt, dy_nxt;
   logic [DIM_W-1:0] sx_d, sy_d;
   logic [FIX_W-1:0] fx_d, fy_d;
   logic             accept;

   // Handshake and status are decoded straight from state so they drop the
   // moment reset is asserted.
   assign spg_start = (state == S_RUN);
   assign busy      = (state != S_IDLE);
   assign done      = (state == S_DONE);
   assign accept    = spg_start && spg_ready;

   // Next-state logic: config latch, raster walk and accumulator stepping.
   always_comb begin
      state_nxt  = state;
      dst_w_nxt  = dst_w_q;
      dst_h_nxt  = dst_h_q;
      src_w_nxt  = src_w_q;
      src_h_nxt  = src_h_q;
      step_x_nxt = step_x_q;
      step_y_nxt = step_y_q;
      acc_x_nxt  = acc_x_q;
      acc_y_nxt  = acc_y_q;
      dx_nxt     = dx_q;
      dy_nxt     = dy_q;
      case (state)
         S_IDLE: begin
            if (cfg_start) begin
               dst_w_nxt  = cfg_dst_w;
               dst_h_nxt  = cfg_dst_h;
               src_w_nxt  = cfg_src_w;
               src_h_nxt  = cfg_src_h;
               step_x_nxt = cfg_step_x;
               step_y_nxt = cfg_step_y;
               acc_x_nxt  = '0;
               acc_y_nxt  = '0;
               dx_nxt     = '0;
               dy_nxt     = '0;
               // Empty frame: no starts, straight to the done pulse.
               if (cfg_dst_w == '0 || cfg_dst_h == '0)
                  state_nxt = S_DONE;
               else
                  state_nxt = S_RUN;
            end
         end
         S_RUN: begin
            if (accept) begin
               if (dx_q != dst_w_q - DIM_W'(1)) begin
                  dx_nxt    = dx_q + DIM_W'(1);
                  acc_x_nxt = acc_x_q + step_x_q;
               end else if (dy_q == dst_h_q - DIM_W'(1)) begin
                  state_nxt = S_DONE;
               end else begin
                  dx_nxt    = '0;
                  acc_x_nxt = '0;
                  dy_nxt    = dy_q + DIM_W'(1);
                  acc_y_nxt = acc_y_q + step_y_q;
               end
            end
         end
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // Source position derived from the upcoming accumulator values so the
   // registered outputs line up with the pixel being offered.
   always_comb begin
      sx_d = acc_x_nxt[FRAC+DIM_W-1:FRAC];
      sy_d = acc_y_nxt[FRAC+DIM_W-1:FRAC];
      fx_d = FIX_W'(acc_x_nxt[FRAC-1:0]);
      fy_d = FIX_W'(acc_y_nxt[FRAC-1:0]);
`ifdef SCALE_CLAMP_EN
      // Replicate the last source column/row: park on the final pair with a
      // full weight on the far sample.
      if (sx_d >= src_w_nxt - DIM_W'(1)) begin
         sx_d = src_w_nxt - DIM_W'(2);
         fx_d = FIX_W'(1) << FRAC;
      end
      if (sy_d >= src_h_nxt - DIM_W'(1)) begin
         sy_d = src_h_nxt - DIM_W'(2);
         fy_d = FIX_W'(1) << FRAC;
      end
`endif
   end

`ifndef SCALE_CLAMP_EN
   // Source size only matters for clamping.
   logic unused_src;
   assign unused_src = ^{src_w_q, src_h_q};
`endif

   // State, config, walker and output registers.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state    <= S_IDLE;
         dst_w_q  <= '0;
         dst_h_q  <= '0;
         src_w_q  <= '0;
         src_h_q  <= '0;
         step_x_q <= '0;
         step_y_q <= '0;
         acc_x_q  <= '0;
         acc_y_q  <= '0;
         dx_q     <= '0;
         dy_q     <= '0;
         spg_sx   <= '0;
         spg_sy   <= '0;
         spg_fx   <= '0;
         spg_fy   <= '0;
         spg_dx   <= '0;
         spg_dy   <= '0;
      end else begin
         state    <= state_nxt;
         dst_w_q  <= dst_w_nxt;
         dst_h_q  <= dst_h_nxt;
         src_w_q  <= src_w_nxt;
         src_h_q  <= src_h_nxt;
         step_x_q <= step_x_nxt;
         step_y_q <= step_y_nxt;
         acc_x_q  <= acc_x_nxt;
         acc_y_q  <= acc_y_nxt;
         dx_q     <= dx_nxt;
         dy_q     <= dy_nxt;
         spg_sx   <= sx_d;
         spg_sy   <= sy_d;
         spg_fx   <= fx_d;
         spg_fy   <= fy_d;
         spg_dx   <= FRAC'(dx_nxt);
         spg_dy   <= FRAC'(dy_nxt);
      end
   end

endmodule

// File: tb/tb_scale_coord_gen.sv
// Scoreboard bench for scale_coord_gen: directed frames push hand-computed
// pixels into a queue; a negedge monitor pops and compares on every accept
// and checks that offered outputs hold while the pixel stage is not ready.
module tb_scale_coord_gen;
   localparam int DIM_W = 12;
   localparam int FRAC  = 18;
   localparam int FIX_W = 36;
   localparam logic [FIX_W-1:0] ONE = FIX_W'(1) << FRAC;

   logic             clk = 1'b0;
   logic             resetn = 1'b0;
   logic             cfg_start = 1'b0;
   logic [DIM_W-1:0] cfg_dst_w = '0, cfg_dst_h = '0, cfg_src_w = '0, cfg_src_h = '0;
   logic [FIX_W-1:0] cfg_step_x = '0, cfg_step_y = '0;
   logic             busy, done, spg_ready = 1'b0, spg_start;
   logic [DIM_W-1:0] spg_sx, spg_sy;
   logic [FIX_W-1:0] spg_fx, spg_fy;
   logic [FRAC-1:0]  spg_dx, spg_dy;

   scale_coord_gen #(.DIM_W(DIM_W), .FRAC(FRAC), .FIX_W(FIX_W)) dut (
      .clk(clk), .resetn(resetn), .cfg_start(cfg_start),
      .cfg_dst_w(cfg_dst_w), .cfg_dst_h(cfg_dst_h),
      .cfg_step_x(cfg_step_x), .cfg_step_y(cfg_step_y),
      .cfg_src_w(cfg_src_w), .cfg_src_h(cfg_src_h),
      .busy(busy), .done(done), .spg_ready(spg_ready), .spg_start(spg_start),
      .spg_sx(spg_sx), .spg_sy(spg_sy), .spg_fx(spg_fx), .spg_fy(spg_fy),
      .spg_dx(spg_dx), .spg_dy(spg_dy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [DIM_W-1:0] sx, sy;
      logic [FIX_W-1:0] fx, fy;
      logic [FRAC-1:0]  dx, dy;
   } pix_t;

   pix_t exp_q[$];
   int   tests = 0, fails = 0;
   int   cyc = 0, acc_cnt = 0, last_acc_cyc = -10;
   bit   hold_vld = 0;
   pix_t hold;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic pix_t cur_pix();
      pix_t p;
      p.sx = spg_sx; p.sy = spg_sy; p.fx = spg_fx; p.fy = spg_fy;
      p.dx = spg_dx; p.dy = spg_dy;
      return p;
   endfunction

   function automatic bit pix_eq(pix_t a, pix_t b);
      return a.sx == b.sx && a.sy == b.sy && a.fx == b.fx && a.fy == b.fy &&
             a.dx == b.dx && a.dy == b.dy;
   endfunction

   function automatic string pix_str(pix_t p);
      return $sformatf("sx=%0d sy=%0d fx=%h fy=%h dx=%0d dy=%0d",
                       p.sx, p.sy, p.fx, p.fy, p.dx, p.dy);
   endfunction

   task automatic push(input int sx, input int sy, input logic [FIX_W-1:0] fx,
                       input logic [FIX_W-1:0] fy, input int dx, input int dy);
      pix_t p;
      p.sx = DIM_W'(sx); p.sy = DIM_W'(sy); p.fx = fx; p.fy = fy;
      p.dx = FRAC'(dx);  p.dy = FRAC'(dy);
      exp_q.push_back(p);
   endtask

   // Monitor: pop/compare on accept, hold-stability while stalled.
   always @(negedge clk) begin
      pix_t a, e;
      if (!resetn) begin
         hold_vld = 0;
      end else begin
         a = cur_pix();
         if (hold_vld && spg_start) begin
            tests++;
            if (!pix_eq(a, hold)) begin
               fails++;
               $display("FAIL hold_stable got %s want %s", pix_str(a), pix_str(hold));
            end
         end
         if (spg_start && spg_ready) begin
            acc_cnt++;
            last_acc_cyc = cyc;
            tests++;
            if (exp_q.size() == 0) begin
               fails++;
               $display("FAIL unexpected_accept got %s want none", pix_str(a));
            end else begin
               e = exp_q.pop_front();
               if (!pix_eq(a, e)) begin
                  fails++;
                  $display("FAIL pixel got %s want %s", pix_str(a), pix_str(e));
               end
            end
            hold_vld = 0;
         end else if (spg_start) begin
            hold_vld = 1;
            hold = a;
         end else begin
            hold_vld = 0;
         end
      end
   end

   task automatic check(input string name, input bit ok, input int act, input int req);
      tests++;
      if (!ok) begin
         fails++;
         $display("FAIL %s got %0d want %0d", name, act, req);
      end
   endtask

   // Run one frame to its done pulse; rmode 1 keeps ready high 1 cycle in 5.
   task automatic do_frame(input string name, input int w, input int h,
                           input logic [FIX_W-1:0] stx, input logic [FIX_W-1:0] sty,
                           input int srcw, input int srch, input int rmode);
      int acc0, wait_c;
      bit seen;
      acc0 = acc_cnt;
      @(posedge clk); #1;
      cfg_dst_w = DIM_W'(w); cfg_dst_h = DIM_W'(h);
      cfg_step_x = stx; cfg_step_y = sty;
      cfg_src_w = DIM_W'(srcw); cfg_src_h = DIM_W'(srch);
      cfg_start = 1'b1;
      spg_ready = (rmode == 0);
      @(posedge clk); #1;
      cfg_start = 1'b0;
      seen = 0; wait_c = 0;
      while (!seen && wait_c < 500) begin
         @(negedge clk);
         if (done) seen = 1;
         else begin
            @(posedge clk); #1;
            wait_c++;
            spg_ready = (rmode == 0) ? 1'b1 : ((wait_c % 5) == 4);
         end
      end
      check({name, "_done_seen"}, seen, int'(seen), 1);
      check({name, "_accepts"}, acc_cnt - acc0 == w * h, acc_cnt - acc0, w * h);
      if (w * h > 0)
         check({name, "_done_lat"}, cyc - last_acc_cyc == 1, cyc - last_acc_cyc, 1);
      else
         check({name, "_done_early"}, wait_c <= 1, wait_c, 1);
      @(negedge clk);
      check({name, "_done_1cyc"}, !done && !busy, int'({done, busy}), 0);
      check({name, "_queue_empty"}, exp_q.size() == 0, exp_q.size(), 0);
      exp_q.delete();
      spg_ready = 1'b0;
   endtask

   task automatic push_t1();
      push(0, 0, 0, 0, 0, 0); push(1, 0, 0, 0, 1, 0);
      push(0, 1, 0, 0, 0, 1); push(1, 1, 0, 0, 1, 1);
   endtask

   initial begin
      int acc0, n;
      // Reset state
      repeat (2) @(negedge clk);
      check("rst_ctrl", !busy && !done && !spg_start, int'({busy, done, spg_start}), 0);
      check("rst_coord", spg_sx == 0 && spg_sy == 0 && spg_fx == 0 && spg_fy == 0 &&
            spg_dx == 0 && spg_dy == 0, int'(spg_sx), 0);
      @(posedge clk); #1 resetn = 1'b1;

      // T1: 2x2 unit step
      push_t1();
      do_frame("t1", 2, 2, ONE, ONE, 8, 8, 0);

      // T2: 3x1 half step in X
      push(0, 0, 0, 0, 0, 0);
      push(0, 0, 36'h20000, 0, 1, 0);
      push(1, 0, 0, 0, 2, 0);
      do_frame("t2", 3, 1, 36'h20000, 36'h40000, 8, 8, 0);

      // T3: 3x2, step 0.75 / 0.625, stalled ready
      push(0, 0, 0, 0, 0, 0);
      push(0, 0, 36'h30000, 0, 1, 0);
      push(1, 0, 36'h20000, 0, 2, 0);
      push(0, 0, 0, 36'h28000, 0, 1);
      push(0, 0, 36'h30000, 36'h28000, 1, 1);
      push(1, 0, 36'h20000, 36'h28000, 2, 1);
      do_frame("t3", 3, 2, 36'h30000, 36'h28000, 8, 8, 1);

      // T4: empty frame
      check("t4_idle_before", !busy, int'(busy), 0);
      do_frame("t4", 0, 5, ONE, ONE, 8, 8, 0);

      // T5: ignored cfg_start mid-frame, then reset mid-frame
      for (int y = 0; y < 2; y++)
         for (int x = 0; x < 3; x++) push(x, y, 0, 0, x, y);
      acc0 = acc_cnt;
      @(posedge clk); #1;
      cfg_dst_w = 3; cfg_dst_h = 2; cfg_step_x = ONE; cfg_step_y = ONE;
      cfg_src_w = 8; cfg_src_h = 8; cfg_start = 1'b1; spg_ready = 1'b1;
      @(posedge clk); #1 cfg_start = 1'b0;
      n = 0;
      while (acc_cnt < acc0 + 2 && n < 50) begin @(negedge clk); n++; end
      @(posedge clk); #1;
      cfg_dst_w = 1; cfg_dst_h = 1; cfg_start = 1'b1;
      @(posedge clk); #1 cfg_start = 1'b0;
      n = 0;
      while (acc_cnt < acc0 + 4 && n < 50) begin @(negedge clk); n++; end
      check("t5_mid_accepts", acc_cnt - acc0 == 4, acc_cnt - acc0, 4);
      @(posedge clk); #2 resetn = 1'b0;
      #1;
      check("t5_rst_start", !spg_start, int'(spg_start), 0);
      check("t5_rst_busy", !busy, int'(busy), 0);
      exp_q.delete();
      repeat (2) @(posedge clk);
      #1 resetn = 1'b1;
      spg_ready = 1'b0;
      @(negedge clk);
      check("t5_idle_after", !busy && !spg_start && !done, int'({busy, spg_start, done}), 0);
      push_t1();
      do_frame("t5_restart", 2, 2, ONE, ONE, 8, 8, 0);

      // T6: 4x1 over a 4-wide source, last column hits the edge
      push(0, 0, 0, 0, 0, 0);
      push(1, 0, 0, 0, 1, 0);
      push(2, 0, 0, 0, 2, 0);
`ifdef SCALE_CLAMP_EN
      push(2, 0, ONE, 0, 3, 0);
`else
      push(3, 0, 0, 0, 3, 0);
`endif
      do_frame("t6", 4, 1, ONE, ONE, 4, 4, 0);

      repeat (2) @(posedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
